// File: rtl/count_mon_pkg.sv
// Shared state encodings and widths for the count monitor block.
package count_mon_pkg;

  localparam int CNT_W    = 3;
  localparam int WRAP_W   = 8;
  localparam int ERRCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_e;

endpackage

// File: rtl/count_mon_satcnt.sv
// Width-parameterised saturating up-counter: holds at all-ones once reached.
module count_mon_satcnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_monitor.sv
// Sequence monitor for a free-running 3-bit counter: flags wraps and skips.
// Optional violation counter output err_cnt enabled by COUNT_MON_ERRCNT_EN.
module count_monitor
  import count_mon_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              clr_err,
  output logic              tc,
  output logic              err_pulse,
  output logic              err,
  output logic [WRAP_W-1:0] wraps,
  output logic [1:0]        state
`ifdef COUNT_MON_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             tc_q, tc_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] prev_inc;
  logic             legal;
  logic             viol;
  logic             wrap;

  assign prev_inc = prev_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign legal    = (cnt == prev_inc);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    viol        = 1'b0;
    wrap        = 1'b0;
    if (!en) begin
      // Disabling parks the FSM but keeps history (prev, wraps, err).
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          // First sample after (re)sync only seeds prev; it is never checked.
          prev_d  = cnt;
          state_d = TRACK;
        end
        TRACK: begin
          if (legal) begin
            prev_d = cnt;
            wrap   = (prev_q == {CNT_W{1'b1}}) && (cnt == '0);
          end else begin
            viol    = 1'b1;
            state_d = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    tc_d        = wrap;
    err_pulse_d = viol;
    // A violation in the same cycle as clr_err keeps the flag set.
    err_d       = viol | (err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      tc_q        <= 1'b0;
      err_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tc_q        <= tc_d;
      err_pulse_q <= err_pulse_d;
      err_q       <= err_d;
    end
  end

  count_mon_satcnt #(
    .WIDTH (WRAP_W)
  ) u_wraps (
    .clk   (clk),
    .rst_n (clr),
    .inc   (wrap),
    .count (wraps)
  );

`ifdef COUNT_MON_ERRCNT_EN
  count_mon_satcnt #(
    .WIDTH (ERRCNT_W)
  ) u_errcnt (
    .clk   (clk),
    .rst_n (clr),
    .inc   (viol),
    .count (err_cnt)
  );
`endif

  assign tc        = tc_q;
  assign err_pulse = err_pulse_q;
  assign err       = err_q;
  assign state     = state_q;

endmodule
